// File: rtl/banked_mem_lsu_if.sv
// Bus bundle between the core/memory side and the banked load/store unit.
//
// Signal groups:
//   req_*   : core request (valid/ready handshake, store flag, size,
//             unsigned flag, byte address, LSB-aligned store data)
//   bank_*  : per-bank enable, write enable, packed word addresses,
//             byte-lane write data and byte-lane read data
//   resp_*  : load response (valid/ready handshake, aligned/extended data)
//   misaligned : one-cycle trap pulse (only active in the trap build)
//
// Modports:
//   slave  : the load/store unit (receives requests, drives banks/responses)
//   master : core plus memory banks (issues requests, returns bank data)
interface banked_mem_lsu_if #(
  parameter int ADDR_W = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [1:0]              req_size;
  logic                    req_unsigned;
  logic [ADDR_W-1:0]       req_addr;
  logic [31:0]             req_wdata;

  logic [3:0]              bank_en;
  logic [3:0]              bank_we;
  logic [4*(ADDR_W-2)-1:0] bank_addr;
  logic [31:0]             bank_wdata;
  logic [31:0]             bank_rdata;

  logic                    resp_valid;
  logic                    resp_ready;
  logic [31:0]             resp_rdata;

  logic                    misaligned;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  bank_rdata, resp_ready,
    output req_ready, bank_en, bank_we, bank_addr, bank_wdata,
    output resp_valid, resp_rdata, misaligned
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output bank_rdata, resp_ready,
    input  req_ready, bank_en, bank_we, bank_addr, bank_wdata,
    input  resp_valid, resp_rdata, misaligned
  );
endinterface

// File: rtl/banked_mem_lsu.sv
// Load/store front end for a 4-bank byte-interleaved data memory.
//
// Byte address A lives in bank A[1:0] at word address A>>2. Every bank gets
// its own word address, so an access that straddles a word boundary still
// completes in a single bank cycle (banks below the offset use word+1).
//
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-high reset
//   bus  : banked_mem_lsu_if.slave (request, bank and response signals)
//
// Parameters:
//   ADDR_W      : byte address width (bank word address is ADDR_W-2 bits)
//   RESET_RDATA : resp_rdata value after reset / when no response is valid
//
// Timing: a load accepted in cycle T drives the banks combinationally in T,
// bank data returns in T+1 and is re-aligned/extended into resp_rdata in
// T+1. A stalled response is parked in a hold register; a second entry
// (spare) catches the one load that can already be in flight when the hold
// fills, so nothing is lost while req_ready is low.
//
// Build option: define MISALIGN_TRAP_EN to suppress bank access for
// misaligned half/word requests, pulse misaligned one cycle after accept
// and return zero data for such loads. Without it misaligned is tied 0.
module banked_mem_lsu #(
  parameter int          ADDR_W      = 32,
  parameter logic [31:0] RESET_RDATA = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  banked_mem_lsu_if.slave bus
);
  localparam int WA_W = ADDR_W - 2;

  typedef logic [WA_W-1:0] waddr_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    return (size == 2'b01 && off[0]) || (size[1] && off != 2'b00);
  endfunction
`endif

  // Rotate bank lanes so byte k of the result comes from lane (off+k)
  // mod 4, then sign/zero-extend for byte and half loads.
  function automatic logic [31:0] align_extend(input logic [31:0] lanes,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [31:0] rot;
    logic [1:0]  lane;
    rot = '0;
    for (int k = 0; k < 4; k++) begin
      lane = off + k[1:0];
      rot[8*k +: 8] = lanes[8*lane +: 8];
    end
    case (size)
      2'b00:   return {{24{~uns & rot[7]}}, rot[7:0]};
      2'b01:   return {{16{~uns & rot[15]}}, rot[15:0]};
      default: return rot;
    endcase
  endfunction

  logic        acc_p0;
  logic        load_p0;
  logic [1:0]  off_p0;
  waddr_t      word_p0;
  waddr_t      word_inc_p0;
  logic [2:0]  nbytes_p0;
  logic        trap_p0;

  logic        vld_p1;
  logic [1:0]  size_p1;
  logic        uns_p1;
  logic [1:0]  off_p1;
  logic [31:0] rdata_p1;

  logic        hold_vld;
  logic [31:0] hold_data;
  logic        spare_vld;
  logic [31:0] spare_data;

  logic        pop;
  logic        hold_from_spare;
  logic        hold_from_p1;
  logic        spare_load;

  // ---- stage p0: request accept and bank issue ----
  assign bus.req_ready = !hold_vld;
  assign acc_p0        = bus.req_valid && bus.req_ready && !rst;
  assign load_p0       = acc_p0 && !bus.req_we;
  assign off_p0        = bus.req_addr[1:0];
  assign word_p0       = bus.req_addr[ADDR_W-1:2];
  assign word_inc_p0   = word_p0 + waddr_t'(1);
  assign nbytes_p0     = size_bytes(bus.req_size);

`ifdef MISALIGN_TRAP_EN
  assign trap_p0 = is_misaligned(bus.req_size, off_p0);
`else
  assign trap_p0 = 1'b0;
`endif

  always_comb begin
    logic [1:0] lane_k;
    logic       en_b;
    lane_k         = '0;
    en_b           = 1'b0;
    bus.bank_en    = '0;
    bus.bank_we    = '0;
    bus.bank_addr  = '0;
    bus.bank_wdata = '0;
    if (acc_p0) begin
      for (int b = 0; b < 4; b++) begin
        // lane_k is the request byte index that lands in bank b
        lane_k = 2'(b) - off_p0;
        en_b   = ({1'b0, lane_k} < nbytes_p0) && !trap_p0;
        bus.bank_en[b]                = en_b;
        bus.bank_we[b]                = en_b && bus.req_we;
        bus.bank_addr[b*WA_W +: WA_W] = (2'(b) < off_p0) ? word_inc_p0 : word_p0;
        bus.bank_wdata[8*b +: 8]      = bus.req_wdata[8*lane_k +: 8];
      end
    end
  end

  // ---- stage p1: load tracking, bank data returns ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= load_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (load_p0) begin
      size_p1 <= bus.req_size;
      uns_p1  <= bus.req_unsigned;
      off_p1  <= off_p0;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic mis_p1;

  // Trap pulse covers both loads and stores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_p1 <= 1'b0;
    end else begin
      mis_p1 <= acc_p0 && trap_p0;
    end
  end

  assign bus.misaligned = mis_p1;
`else
  assign bus.misaligned = 1'b0;
`endif

  always_comb begin
    rdata_p1 = align_extend(bus.bank_rdata, off_p1, size_p1, uns_p1);
`ifdef MISALIGN_TRAP_EN
    if (mis_p1) rdata_p1 = '0;
`endif
  end

  // ---- response: hold/spare skid entries ----
  assign bus.resp_valid = hold_vld || vld_p1;
  assign bus.resp_rdata = hold_vld ? hold_data :
                          vld_p1   ? rdata_p1  : RESET_RDATA;

  // Hold is the visible head; spare only fills when a load was already in
  // flight as the hold filled, and drains into hold on the next pop.
  assign pop             = hold_vld && bus.resp_ready;
  assign hold_from_spare = pop && spare_vld;
  assign hold_from_p1    = vld_p1 && ((!hold_vld && !bus.resp_ready) ||
                                      (pop && !spare_vld));
  assign spare_load      = vld_p1 && hold_vld && !bus.resp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_vld  <= 1'b0;
      spare_vld <= 1'b0;
    end else begin
      hold_vld  <= hold_from_spare || hold_from_p1 ||
                   (hold_vld && !bus.resp_ready);
      spare_vld <= spare_load || (spare_vld && !bus.resp_ready);
    end
  end

  always_ff @(posedge clk) begin
    if (hold_from_spare) begin
      hold_data <= spare_data;
    end else if (hold_from_p1) begin
      hold_data <= rdata_p1;
    end
    if (spare_load) begin
      spare_data <= rdata_p1;
    end
  end
endmodule

// File: doc/banked_mem_lsu.md
Name: banked_mem_lsu

Overview:
- Load/store front end for the 4-bank byte-interleaved data memory.
- Takes core load/store requests through a valid/ready handshake and drives each bank its own address, enable, write strobe and rotated write byte.
- Captures bank read data one cycle later, then re-aligns and sign/zero-extends it.
- Misaligned accesses complete in one bank cycle: each bank has an independent word address.

Parameters:
- ADDR_W, 32, byte address width; bank word address width is ADDR_W-2.
- RESET_RDATA, 32'h0, value of resp_rdata after reset and when no response is valid.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_unsigned  in  1  load zero-extend (LBU/LHU)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, LSB-aligned
- bank_en  out  4  per-bank access enable, bit b = bank b
- bank_we  out  4  per-bank write enable
- bank_addr  out  4*(ADDR_W-2)  packed word addresses, bank b at slice b
- bank_wdata  out  32  byte lane b to bank b
- bank_rdata  in  32  lane b from bank b, valid one cycle after enable
- resp_valid  out  1  load data available
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  aligned, extended load data
- misaligned  out  1  one-cycle pulse, optional feature only

Behaviour:
- Decided: one clock; reset is asynchronous and active-high.
- Terms: N = bytes (1/2/4); o = req_addr[1:0]; W = req_addr>>2.
- Issue (combinational in the accept cycle):
  - Bank b is enabled iff k = (b-o) mod 4 < N.
  - bank_addr[b] = W+1 if b<o, else W; the +1 wraps modulo 2^(ADDR_W-2).
  - bank_we[b] = bank_en[b] && req_we.
  - bank_wdata lane b = req_wdata byte k.
  - All bank outputs are 0 when no request is accepted.
- Stage1 registers (on accepted load): s1_valid, size, unsigned, o. Stores do not load stage1 and produce no response.
- Load latency: accept at cycle T -> resp_valid at T+1.
  - Result byte k = bank_rdata lane (o+k) mod 4 for k<N.
  - Upper bytes: sign-extended from bit 8N-1 unless unsigned; word ignores unsigned.
- Hold register (skid buffer):
  - If resp_valid && !resp_ready, the aligned word is captured into hold; hold_valid=1.
  - resp_rdata comes from hold while hold_valid.
  - Cleared on resp_ready.
- req_ready = !hold_valid.
- Throughput is one request per cycle while resp_ready=1.
- A store accepted while stage1 holds a load completes normally and does not disturb that load's data.
- Reset (any time, mid-operation included): s1_valid=0, hold_valid=0, resp_valid=0, resp_rdata=RESET_RDATA, misaligned=0, all bank outputs 0. req_ready=1 after reset.
- A load in flight when reset asserts is dropped; no response is produced.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A request with (size=01 && o[0]) or (size>=10 && o!=0) is still accepted.
  - bank_en/bank_we stay 0 for it.
  - misaligned pulses 1 at T+1.
  - A misaligned load still returns resp_valid at T+1 with resp_rdata=0.
- Undefined: misaligned is tied 0 and misaligned accesses execute across banks as above.

Test Plan:
- Aligned store SW addr=0x100 data=0xDDCCBBAA -> bank_en=1111, bank_we=1111, all bank_addr=0x40, lanes 0..3 = AA,BB,CC,DD. Then LW 0x100 -> resp_rdata=0xDDCCBBAA at T+1.
- Misaligned SW addr=0x103 data=0x44332211 -> bank3 addr 0x40 gets 11; banks 0,1,2 addr 0x41 get 22,33,44. LW 0x103 -> 0x44332211.
- Memory byte 0x80 at addr 0x102 -> LB gives 0xFFFFFF80, LBU gives 0x00000080. LH 0x101 over bytes 0x00,0x80 -> 0xFFFF8000.
- Back-to-back loads with resp_ready held 0 for 3 cycles:
  - First response held stable; req_ready=0 during hold.
  - Second load issued only after acceptance.
  - No data lost or duplicated.
- Word-address wrap: ADDR_W=32, LW addr=0xFFFFFFFE -> banks 2,3 at 0x3FFFFFFF, banks 0,1 at 0x0.
- rst asserted the cycle after a load accept -> resp_valid stays 0, outputs at reset values. With MISALIGN_TRAP_EN, LH 0x101 -> bank_en=0000, misaligned=1 and resp_rdata=0 at T+1.
